// File: rtl/atoi_scheduler.sv
// Arbitrates NUM_REQ requesters onto one atoi converter: buffers a requester's string,
// bursts it gap-free into the converter, then returns the tagged result.
module atoi_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 32,
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT      = 4,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [4*NUM_REQ-1:0]           req_base,
    input  logic [NUM_REQ-1:0]             chr_valid,
    input  logic [INPUT_WIDTH*NUM_REQ-1:0] chr_data,
    input  logic [NUM_REQ-1:0]             chr_last,
    output logic [NUM_REQ-1:0]             chr_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [INPUT_WIDTH-1:0]         cv_data,
    output logic                           cv_sop,
    output logic                           cv_eop,
    input  logic [OUTPUT_WIDTH-1:0]        cv_number,
    input  logic                           cv_valid,
    input  logic                           cv_error,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [ID_W-1:0]                resp_id,
    output logic [OUTPUT_WIDTH-1:0]        resp_number,
    output logic                           resp_error,
    output logic                           busy,
    output logic [2:0]                     dbg_state
);
    localparam int PTR_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PTR_W-1:0] MAX_PTR  = PTR_W'(MAX_LEN);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_SOP, S_BURST, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         id_q, id_d, last_q, last_d;
    logic [3:0]              base_q, base_d;
    logic                    bad_q, bad_d, ovf_q, ovf_d, err_q, err_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, len_q, len_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [OUTPUT_WIDTH-1:0] num_q, num_d;
    logic [INPUT_WIDTH-1:0]  char_buf_q [MAX_LEN];

    logic                    buf_we, found, at_eop;
    logic [ID_W-1:0]         pick, cand;
    logic [3:0]              base_sel;
    logic [INPUT_WIDTH-1:0]  chr_sel;
    logic [NUM_REQ-1:0]      owner_oh;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        last_d   = last_q;
        base_d   = base_q;
        bad_d    = bad_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        timer_d  = timer_q;
        num_d    = num_q;
        buf_we   = 1'b0;
        found    = 1'b0;
        pick     = last_q;
        cand     = last_q;
        at_eop   = (rd_ptr_q == len_q - PTR_ONE);

        // Round-robin: the requester just served has the lowest priority next time.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        base_sel = req_base[int'(pick)*4 +: 4];
        chr_sel  = chr_data[int'(id_q)*INPUT_WIDTH +: INPUT_WIDTH];

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    id_d     = pick;
                    base_d   = base_sel;
                    bad_d    = (base_sel < 4'd2) || (base_sel > 4'd10);
                    wr_ptr_d = '0;
                    ovf_d    = 1'b0;
                    timer_d  = '0;
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (chr_valid[id_q]) begin
                    if (wr_ptr_q < MAX_PTR) begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    // Rejected strings never reach the converter.
                    if (chr_last[id_q]) begin
                        if (bad_q || ovf_d) begin
                            num_d   = '0;
                            err_d   = 1'b1;
                            state_d = S_RESP;
                        end else begin
                            len_d   = wr_ptr_d;
                            state_d = S_SOP;
                        end
                    end
                end
            end
            S_SOP: begin
                rd_ptr_d = '0;
                state_d  = S_BURST;
            end
            S_BURST: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (at_eop) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cv_valid) begin
                    num_d   = cv_number;
                    err_d   = cv_error;
                    state_d = S_RESP;
                end else if (timer_q == TMR_LAST) begin
                    num_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    last_d  = id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            last_q   <= ID_W'(NUM_REQ - 1);
            base_q   <= '0;
            bad_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            timer_q  <= '0;
            num_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            last_q   <= last_d;
            base_q   <= base_d;
            bad_q    <= bad_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            timer_q  <= timer_d;
            num_q    <= num_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) char_buf_q[wr_ptr_q[IDX_W-1:0]] <= chr_sel;
    end

    // Converter-facing outputs depend only on state and registers, never on requester inputs.
    always_comb begin
        owner_oh    = NUM_REQ'(1) << id_q;
        grant       = (state_q != S_IDLE) ? owner_oh : '0;
        chr_ready   = (state_q == S_COLLECT) ? owner_oh : '0;
        cv_sop      = (state_q == S_SOP);
        cv_eop      = (state_q == S_BURST) && at_eop;
        cv_data     = '0;
        if (state_q == S_SOP)   cv_data = {{(INPUT_WIDTH-4){1'b0}}, base_q};
        if (state_q == S_BURST) cv_data = char_buf_q[rd_ptr_q[IDX_W-1:0]];
        resp_valid  = (state_q == S_RESP);
        resp_id     = resp_valid ? id_q : '0;
        resp_number = resp_valid ? num_q : '0;
        resp_error  = resp_valid && err_q;
        busy        = (state_q != S_IDLE);
        dbg_state   = state_q;
    end
endmodule
